alt_vipcti131_mode_select_sync: RTL and testbench

- Control-side counterpart of the CVI one-hot-to-binary mode encoder.
- Accepts a binary mode index over a valid/ready handshake and range-checks it.
- Decodes the index to a one-hot mode-bank select and commits the change only on a video frame boundary (sof).
- Sits between the control/register slave and the per-mode timing banks of the clocked video path.

---
 rtl/alt_vipcti131_mode_select_sync_pkg.sv | 19 +
 rtl/alt_vipcti131_mode_select_sync_if.sv | 28 ++
 rtl/alt_vipcti131_binary_to_one_hot.sv | 19 +
 rtl/alt_vipcti131_mode_select_sync.sv | 97 +++++++++
 tb/tb_alt_vipcti131_mode_select_sync.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/alt_vipcti131_mode_select_sync_pkg.sv
// Shared types and helpers for the mode-select synchroniser.
package alt_vipcti131_mode_select_sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam int unsigned MODE_NONE = 0;

  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/alt_vipcti131_mode_select_sync_if.sv
// Request/status bundle between the control slave and the mode-select block.
interface alt_vipcti131_mode_select_sync_if #(
  parameter int unsigned NO_OF_MODES      = 3,
  parameter int unsigned LOG2_NO_OF_MODES = 2
);

  logic                        req_valid;
  logic                        req_ready;
  logic [LOG2_NO_OF_MODES-1:0] req_binary;
  logic                        cancel;
  logic                        sof;
  logic [NO_OF_MODES-1:0]      one_hot;
  logic [LOG2_NO_OF_MODES-1:0] binary_active;
  logic                        pending;
  logic                        change_done;
  logic                        err;

  modport master (
    output req_valid, req_binary, cancel, sof,
    input  req_ready, one_hot, binary_active, pending, change_done, err
  );

  modport slave (
    input  req_valid, req_binary, cancel, sof,
    output req_ready, one_hot, binary_active, pending, change_done, err
  );

endinterface

// File: rtl/alt_vipcti131_binary_to_one_hot.sv
// Binary mode index to one-hot bank select; index k selects bit k-1, 0 selects none.
module alt_vipcti131_binary_to_one_hot #(
  parameter int unsigned NO_OF_MODES      = 3,
  parameter int unsigned LOG2_NO_OF_MODES = 2
) (
  input  logic [LOG2_NO_OF_MODES-1:0] bin_i,
  output logic [NO_OF_MODES-1:0]      one_hot_o,
  output logic                        in_range_o
);

  always_comb begin
    one_hot_o = '0;
    for (int unsigned i = 0; i < NO_OF_MODES; i++) begin
      one_hot_o[i] = (32'(bin_i) == i + 1);
    end
    in_range_o = (32'(bin_i) <= NO_OF_MODES);
  end

endmodule

// File: rtl/alt_vipcti131_mode_select_sync.sv
// Accepts a binary mode request, range-checks it and commits the one-hot bank
// select on a frame boundary (or at once when no mode is active).
module alt_vipcti131_mode_select_sync
  import alt_vipcti131_mode_select_sync_pkg::*;
#(
  parameter int unsigned NO_OF_MODES               = 3,
  parameter int unsigned LOG2_NO_OF_MODES          = ceil_log2(NO_OF_MODES + 1),
  parameter int unsigned APPLY_IMMEDIATE_WHEN_IDLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  alt_vipcti131_mode_select_sync_if.slave bus
);

  state_e                      state_q, state_d;
  logic [LOG2_NO_OF_MODES-1:0] mode_q, mode_d;
  logic [LOG2_NO_OF_MODES-1:0] active_q, active_d;
  logic [NO_OF_MODES-1:0]      one_hot_q, one_hot_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic [LOG2_NO_OF_MODES-1:0] dec_bin;
  logic [NO_OF_MODES-1:0]      dec_one_hot;
  logic                        dec_in_range;

  // One decoder serves both jobs: in IDLE it range-checks the incoming
  // request, otherwise it decodes the held mode for the COMMIT edge.
  assign dec_bin = (state_q == IDLE) ? bus.req_binary : mode_q;

  alt_vipcti131_binary_to_one_hot #(
    .NO_OF_MODES      (NO_OF_MODES),
    .LOG2_NO_OF_MODES (LOG2_NO_OF_MODES)
  ) u_decode (
    .bin_i      (dec_bin),
    .one_hot_o  (dec_one_hot),
    .in_range_o (dec_in_range)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    active_d  = active_q;
    one_hot_d = one_hot_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (!dec_in_range) begin
            err_d = 1'b1;
          end else begin
            mode_d = bus.req_binary;
            if ((APPLY_IMMEDIATE_WHEN_IDLE != 0) && (one_hot_q == '0)) state_d = COMMIT;
            else                                                       state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (bus.cancel)   state_d = IDLE;
        else if (bus.sof) state_d = COMMIT;
      end
      COMMIT: begin
        one_hot_d = dec_one_hot;
        active_d  = mode_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= LOG2_NO_OF_MODES'(MODE_NONE);
      active_q  <= LOG2_NO_OF_MODES'(MODE_NONE);
      one_hot_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      active_q  <= active_d;
      one_hot_q <= one_hot_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.pending       = (state_q == PENDING);
  assign bus.one_hot       = one_hot_q;
  assign bus.binary_active = active_q;
  assign bus.change_done   = done_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_alt_vipcti131_mode_select_sync.sv
// Drives a 3-mode and a 2-mode build with identical stimulus and compares
// each against a transaction-level reference model every cycle.
module tb_alt_vipcti131_mode_select_sync;

  localparam int unsigned NA = 3;
  localparam int unsigned NB = 2;
  localparam int unsigned LW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alt_vipcti131_mode_select_sync_if #(.NO_OF_MODES(NA), .LOG2_NO_OF_MODES(LW)) bus_a ();
  alt_vipcti131_mode_select_sync_if #(.NO_OF_MODES(NB), .LOG2_NO_OF_MODES(LW)) bus_b ();

  alt_vipcti131_mode_select_sync #(
    .NO_OF_MODES(NA), .LOG2_NO_OF_MODES(LW), .APPLY_IMMEDIATE_WHEN_IDLE(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  alt_vipcti131_mode_select_sync #(
    .NO_OF_MODES(NB), .LOG2_NO_OF_MODES(LW), .APPLY_IMMEDIATE_WHEN_IDLE(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: committed mode, request waiting for sof (-1 = none),
  // request committing on the next edge (-1 = none).
  int m_n[2]      = '{NA, NB};
  int m_active[2] = '{0, 0};
  int m_held[2]   = '{-1, -1};
  int m_commit[2] = '{-1, -1};
  bit m_done[2]   = '{0, 0};
  bit m_err[2]    = '{0, 0};

  task automatic model_edge(input int k, input int v, input int b, input int c, input int s, input int r);
    bit ready;
    int nc;
    if (r != 0) begin
      m_active[k] = 0; m_held[k] = -1; m_commit[k] = -1;
      m_done[k] = 0; m_err[k] = 0;
      return;
    end
    ready = (m_held[k] < 0) && (m_commit[k] < 0);
    m_done[k] = (m_commit[k] >= 0);
    m_err[k] = 0;
    nc = -1;
    if (m_held[k] >= 0) begin
      if (c != 0) m_held[k] = -1;
      else if (s != 0) begin nc = m_held[k]; m_held[k] = -1; end
    end else if (ready && v != 0) begin
      if (b > m_n[k])          m_err[k] = 1;
      else if (m_active[k] == 0) nc = b;
      else                     m_held[k] = b;
    end
    if (m_commit[k] >= 0) m_active[k] = m_commit[k];
    m_commit[k] = nc;
  endtask

  function automatic int exp_one_hot(input int k);
    return (m_active[k] == 0) ? 0 : (1 << (m_active[k] - 1));
  endfunction

  task automatic check_all();
    check("a_one_hot",  32'(bus_a.one_hot),       32'(exp_one_hot(0)));
    check("a_bin_act",  32'(bus_a.binary_active), 32'(m_active[0]));
    check("a_pending",  32'(bus_a.pending),       32'(m_held[0] >= 0));
    check("a_ready",    32'(bus_a.req_ready),     32'(m_held[0] < 0 && m_commit[0] < 0));
    check("a_done",     32'(bus_a.change_done),   32'(m_done[0]));
    check("a_err",      32'(bus_a.err),           32'(m_err[0]));
    check("b_one_hot",  32'(bus_b.one_hot),       32'(exp_one_hot(1)));
    check("b_bin_act",  32'(bus_b.binary_active), 32'(m_active[1]));
    check("b_pending",  32'(bus_b.pending),       32'(m_held[1] >= 0));
    check("b_ready",    32'(bus_b.req_ready),     32'(m_held[1] < 0 && m_commit[1] < 0));
    check("b_done",     32'(bus_b.change_done),   32'(m_done[1]));
    check("b_err",      32'(bus_b.err),           32'(m_err[1]));
  endtask

  task automatic cycle(input int v, input int b, input int c, input int s, input int r);
    rst              = (r != 0);
    bus_a.req_valid  = (v != 0); bus_b.req_valid  = (v != 0);
    bus_a.req_binary = LW'(b);   bus_b.req_binary = LW'(b);
    bus_a.cancel     = (c != 0); bus_b.cancel     = (c != 0);
    bus_a.sof        = (s != 0); bus_b.sof        = (s != 0);
    @(posedge clk);
    model_edge(0, v, b, c, s, r);
    model_edge(1, v, b, c, s, r);
    #1;
    check_all();
  endtask

  initial begin
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    check("rst_ready", 32'(bus_a.req_ready), 32'd1);
    check("rst_oh",    32'(bus_a.one_hot),   32'd0);

    // Immediate path: mode 2 from no active mode.
    cycle(1, 2, 0, 0, 0);
    check("imm_oh_wait", 32'(bus_a.one_hot), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("imm_oh",   32'(bus_a.one_hot),       32'b010);
    check("imm_bin",  32'(bus_a.binary_active), 32'd2);
    check("imm_done", 32'(bus_a.change_done),   32'd1);

    // Mode 3 waits for sof; the 2-mode build rejects it.
    cycle(1, 3, 0, 0, 0);
    check("rej_err",   32'(bus_b.err),       32'd1);
    check("rej_ready", 32'(bus_b.req_ready), 32'd1);
    check("rej_oh",    32'(bus_b.one_hot),   32'b10);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
    check("hold_pend",  32'(bus_a.pending),   32'd1);
    check("hold_ready", 32'(bus_a.req_ready), 32'd0);
    check("hold_oh",    32'(bus_a.one_hot),   32'b010);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("sof_oh",   32'(bus_a.one_hot),     32'b100);
    check("sof_done", 32'(bus_a.change_done), 32'd1);

    // Move to mode 1, then request 0 on the same edge as a sof.
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("m1_oh", 32'(bus_a.one_hot), 32'b001);
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    check("coinc_oh",   32'(bus_a.one_hot), 32'b001);
    check("coinc_pend", 32'(bus_a.pending), 32'd1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("zero_oh",  32'(bus_a.one_hot),       32'd0);
    check("zero_bin", 32'(bus_a.binary_active), 32'd0);

    // Cancel beats a simultaneous sof.
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("cancel_done", 32'(bus_a.change_done), 32'd0);
    check("cancel_oh",   32'(bus_a.one_hot),     32'b010);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("after_cancel_oh", 32'(bus_a.one_hot), 32'b001);

    // Reset while pending, together with sof.
    cycle(1, 2, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    check("rstp_oh",    32'(bus_a.one_hot),   32'd0);
    check("rstp_pend",  32'(bus_a.pending),   32'd0);
    check("rstp_ready", 32'(bus_a.req_ready), 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("rstp_done", 32'(bus_a.change_done), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(1, 0) == 1) ? 1 : 0,
            int'($urandom_range(3, 0)),
            ($urandom_range(9, 0) == 0) ? 1 : 0,
            ($urandom_range(6, 0) == 0) ? 1 : 0,
            ($urandom_range(49, 0) == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
